data_checker: RTL and testbench

Stream sink closing the loop on the data source feeding the SPI core. It consumes words over the valid/ready interface, locks onto the first received value, and checks that every later word is the previous word plus one, modulo 2^P_DATA_WIDTH. It reports lock status, a sticky error flag, saturating error and wrapping word counters, and the last bad word. A programmable ready-throttle lets the bench and board exercise back-pressure on the source.

---
 rtl/data_checker.sv | 118 +++++++++++
 tb/tb_data_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_checker.sv
// data_checker: stream sink that locks onto the first accepted word and then
// expects each subsequent word to be the previous word plus one (wrapping).
// Reports lock, a sticky error flag, a saturating mismatch count, a wrapping
// accepted-word count and the last mismatched value. A fixed ready throttle
// lets the source be exercised under back-pressure.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | disabled; ready low, status held
// ST_SYNC  | waiting for the lock word (never checked)
// ST_CHECK | comparing every accepted word against expected
module data_checker #(
  parameter int P_DATA_WIDTH     = 8,
  parameter int P_READY_PERIOD   = 1,
  parameter int P_ERR_CNT_WIDTH  = 16,
  parameter int P_WORD_CNT_WIDTH = 16
) (
  input  logic                        clk_100,
  input  logic                        a_rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        valid,
  input  logic [P_DATA_WIDTH-1:0]     data,
  output logic                        ready,
  output logic                        locked,
  output logic                        error,
  output logic [P_ERR_CNT_WIDTH-1:0]  err_cnt,
  output logic [P_WORD_CNT_WIDTH-1:0] word_cnt,
  output logic [P_DATA_WIDTH-1:0]     last_bad
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [7:0]                  THR_LAST = 8'(P_READY_PERIOD - 1);
  localparam logic [P_DATA_WIDTH-1:0]     DATA_ONE = P_DATA_WIDTH'(1);
  localparam logic [P_ERR_CNT_WIDTH-1:0]  ERR_ONE  = P_ERR_CNT_WIDTH'(1);
  localparam logic [P_WORD_CNT_WIDTH-1:0] WORD_ONE = P_WORD_CNT_WIDTH'(1);

  state_t                  state;
  state_t                  state_next;
  logic [7:0]              thr;
  logic [7:0]              thr_next;
  logic                    ready_next;
  logic [P_DATA_WIDTH-1:0] expected;
  logic                    beat;
  logic                    take;

  // A beat that coincides with clear completes the handshake but is dropped.
  assign beat = valid && ready;
  assign take = beat && !clear;

  // Next state, throttle advance and the registered-ready decision.
  always_comb begin
    state_next = state;
    thr_next   = '0;
    ready_next = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else if (clear) begin
      state_next = ST_SYNC;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_SYNC;
        ST_SYNC:  if (beat) state_next = ST_CHECK;
        ST_CHECK: state_next = ST_CHECK;
        default:  state_next = ST_IDLE;
      endcase
    end
    if (state != ST_IDLE && !clear) begin
      thr_next = (thr == THR_LAST) ? 8'd0 : thr + 8'd1;
    end
    ready_next = (state != ST_IDLE) && enable && !clear && (thr_next == 8'd0);
  end

  // Control registers: state, throttle, ready and lock indication.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state  <= ST_IDLE;
      thr    <= '0;
      ready  <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      thr    <= thr_next;
      ready  <= ready_next;
      locked <= (state_next == ST_CHECK);
    end
  end

  // Datapath: counters, expected value and mismatch capture on each beat.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      expected <= '0;
      error    <= 1'b0;
      err_cnt  <= '0;
      word_cnt <= '0;
      last_bad <= '0;
    end else if (clear) begin
      error    <= 1'b0;
      err_cnt  <= '0;
      word_cnt <= '0;
      last_bad <= '0;
    end else if (take) begin
      word_cnt <= word_cnt + WORD_ONE;
      expected <= data + DATA_ONE;
      if (state == ST_CHECK && data != expected) begin
        error    <= 1'b1;
        last_bad <= data;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_data_checker.sv
// tb_data_checker: directed bench for data_checker with a scoreboard of
// expected status per accepted word. One instance runs with an unthrottled
// ready and a 4-bit error counter; a second runs with a ready period of 4.
module tb_data_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready, locked, error;
  logic [3:0]  err_cnt;
  logic [15:0] word_cnt;
  logic [7:0]  last_bad;

  logic        en4 = 1'b0;
  logic        clr4 = 1'b0;
  logic        valid4 = 1'b0;
  logic [7:0]  data4 = 8'h20;
  logic        ready4, locked4, error4;
  logic [15:0] err_cnt4, word_cnt4;
  logic [7:0]  last_bad4;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] wc;
    logic [3:0]  ec;
    logic        err;
    logic [7:0]  lb;
    logic        lk;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_wc;
  logic [3:0]  m_ec;
  logic        m_err;
  logic [7:0]  m_lb;
  logic        m_lk;
  logic [7:0]  m_exp;

  always #5 clk = ~clk;

  data_checker #(
    .P_DATA_WIDTH(8), .P_READY_PERIOD(1), .P_ERR_CNT_WIDTH(4), .P_WORD_CNT_WIDTH(16)
  ) dut (
    .clk_100(clk), .a_rst_n(rst_n), .enable(enable), .clear(clear),
    .valid(valid), .data(data), .ready(ready), .locked(locked),
    .error(error), .err_cnt(err_cnt), .word_cnt(word_cnt), .last_bad(last_bad)
  );

  data_checker #(
    .P_DATA_WIDTH(8), .P_READY_PERIOD(4), .P_ERR_CNT_WIDTH(16), .P_WORD_CNT_WIDTH(16)
  ) dut4 (
    .clk_100(clk), .a_rst_n(rst_n), .enable(en4), .clear(clr4),
    .valid(valid4), .data(data4), .ready(ready4), .locked(locked4),
    .error(error4), .err_cnt(err_cnt4), .word_cnt(word_cnt4), .last_bad(last_bad4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wc = '0; m_ec = '0; m_err = 1'b0; m_lb = '0; m_lk = 1'b0; m_exp = '0;
  endtask

  task automatic model_beat(input logic [7:0] d);
    if (m_lk && d != m_exp) begin
      m_err = 1'b1;
      m_lb  = d;
      if (m_ec != 4'hF) m_ec = m_ec + 4'd1;
    end
    m_lk  = 1'b1;
    m_exp = d + 8'd1;
    m_wc  = m_wc + 16'd1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    chk({tag, "_last_bad"}, 32'(last_bad), 32'd0);
  endtask

  // Drive one word, wait (bounded) for acceptance, then score the result.
  task automatic send(input logic [7:0] d);
    int n;
    exp_t e;
    n = 0;
    valid = 1'b1;
    data  = d;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      chk($sformatf("ready_timeout_%02h", d), 32'(ready), 32'd1);
      valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid = 1'b0;
    model_beat(d);
    sb.push_back('{wc: m_wc, ec: m_ec, err: m_err, lb: m_lb, lk: m_lk});
    e = sb.pop_front();
    chk($sformatf("word_cnt_%02h", d), 32'(word_cnt), 32'(e.wc));
    chk($sformatf("err_cnt_%02h", d), 32'(err_cnt), 32'(e.ec));
    chk($sformatf("error_%02h", d), 32'(error), 32'(e.err));
    chk($sformatf("last_bad_%02h", d), 32'(last_bad), 32'(e.lb));
    chk($sformatf("locked_%02h", d), 32'(locked), 32'(e.lk));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    int first, last, beats;
    logic pending;
    model_clear();

    // Reset state
    #2;
    check_outputs_zero("rst");
    chk("rst_ready4", 32'(ready4), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Enable latency: ready two edges after enable is first sampled
    enable = 1'b1;
    @(posedge clk); #1;
    chk("en_ready_n", 32'(ready), 32'd0);
    chk("en_locked_n", 32'(locked), 32'd0);
    @(posedge clk); #1;
    chk("en_ready_n1", 32'(ready), 32'd1);

    // Incrementing sequence 0x05..0x14
    for (int i = 5; i <= 20; i++) send(8'(i));
    chk("seq_word_cnt", 32'(word_cnt), 32'd16);

    // Wrap across 0xFF -> 0x00
    pulse_clear();
    chk("clr_word_cnt", 32'(word_cnt), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    send(8'hFD); send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    chk("wrap_err_cnt", 32'(err_cnt), 32'd0);
    chk("wrap_word_cnt", 32'(word_cnt), 32'd5);

    // Skip then duplicate: each counts once
    pulse_clear();
    send(8'h01); send(8'h02); send(8'h04); send(8'h05);
    chk("skip_err_cnt", 32'(err_cnt), 32'd1);
    chk("skip_last_bad", 32'(last_bad), 32'h04);
    send(8'h05); send(8'h06);
    chk("dup_err_cnt", 32'(err_cnt), 32'd2);
    chk("dup_last_bad", 32'(last_bad), 32'h05);

    // Drop enable mid-stream, restart the source at 0x80
    enable = 1'b0;
    @(posedge clk); #1;
    m_lk = 1'b0;
    chk("dis_ready", 32'(ready), 32'd0);
    chk("dis_locked", 32'(locked), 32'd0);
    chk("dis_word_cnt_held", 32'(word_cnt), 32'd6);
    chk("dis_err_cnt_held", 32'(err_cnt), 32'd2);
    @(posedge clk); #1;
    enable = 1'b1;
    send(8'h80); send(8'h81); send(8'h82);
    chk("relock_err_cnt", 32'(err_cnt), 32'd2);
    chk("relock_word_cnt", 32'(word_cnt), 32'd9);

    // Clear coincident with a beat: word discarded
    chk("clrbeat_ready_pre", 32'(ready), 32'd1);
    valid = 1'b1;
    data  = 8'h83;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    valid = 1'b0;
    model_clear();
    check_outputs_zero("clrbeat");
    send(8'h10);
    chk("clrbeat_next_wc", 32'(word_cnt), 32'd1);

    // Error counter saturation at 4 bits
    for (int i = 0; i < 20; i++) send((i % 2 == 0) ? 8'h00 : 8'h55);
    chk("sat_err_cnt", 32'(err_cnt), 32'hF);
    chk("sat_word_cnt", 32'(word_cnt), 32'd21);

    // Asynchronous reset mid-burst
    valid = 1'b1;
    data  = 8'h56;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("arst");
    valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    send(8'h42); send(8'h43);
    chk("post_rst_err", 32'(error), 32'd0);

    // Throttle: period 4, valid held high, data advances only on a beat
    first = -1; last = -1; beats = 0; pending = 1'b0;
    en4 = 1'b1;
    valid4 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (pending) begin
        data4 = data4 + 8'd1;
        pending = 1'b0;
      end
      if (ready4) begin
        if (first < 0) first = c;
        if (last >= 0) chk($sformatf("thr_gap_c%0d", c), 32'(c - last), 32'd4);
        last = c;
        beats++;
        pending = 1'b1;
      end
    end
    @(posedge clk); #1;
    valid4 = 1'b0;
    @(posedge clk); #1;
    chk("thr_first", 32'(first), 32'd4);
    chk("thr_beats", 32'(beats), 32'd14);
    chk("thr_word_cnt", 32'(word_cnt4), 32'd14);
    chk("thr_err_cnt", 32'(err_cnt4), 32'd0);
    chk("thr_error", 32'(error4), 32'd0);
    chk("thr_locked", 32'(locked4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
